riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu_pkg.sv | 32 +++
 rtl/riscv_lsu_align.sv | 53 +++++
 rtl/riscv_lsu.sv | 142 ++++++++++++++
 tb/tb_riscv_lsu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the size decode used by both the FSM and the lane aligner.
package riscv_lsu_pkg;

    localparam logic [2:0] RW_B   = 3'b000;
    localparam logic [2:0] RW_H   = 3'b001;
    localparam logic [2:0] RW_W   = 3'b010;
    localparam logic [2:0] RW_D   = 3'b011;
    localparam logic [2:0] RW_BU  = 3'b100;
    localparam logic [2:0] RW_HU  = 3'b101;
    localparam logic [2:0] RW_WU  = 3'b110;
    localparam logic [2:0] RW_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsuState_t;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [3:0] sizeBytes(input logic [2:0] rwType);
        case (rwType)
            RW_B, RW_BU: sizeBytes = 4'd1;
            RW_H, RW_HU: sizeBytes = 4'd2;
            RW_W, RW_WU: sizeBytes = 4'd4;
            RW_D:        sizeBytes = 4'd8;
            default:     sizeBytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables and store-lane placement for the
// incoming request, load extraction and sign/zero extension for the response.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int OFF_W      = $clog2(BE_WIDTH)
) (
    input  logic [2:0]            reqType,
    input  logic [OFF_W-1:0]      reqOff,
    input  logic [DATA_WIDTH-1:0] reqData,
    output logic [BE_WIDTH-1:0]   reqBe,
    output logic [DATA_WIDTH-1:0] reqWdata,
    input  logic [2:0]            rspType,
    input  logic [OFF_W-1:0]      rspOff,
    input  logic [DATA_WIDTH-1:0] rspData,
    output logic [DATA_WIDTH-1:0] rspExt
);

    logic [3:0]            reqSize;
    logic [BE_WIDTH-1:0]   sizeMask;
    logic [DATA_WIDTH-1:0] dataMask;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        reqSize  = sizeBytes(reqType);
        sizeMask = '0;
        dataMask = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (i < int'(reqSize)) begin
                sizeMask[i]       = 1'b1;
                dataMask[8*i +: 8] = 8'hFF;
            end
        end
        reqBe    = sizeMask << reqOff;
        reqWdata = (reqData & dataMask) << {reqOff, 3'b000};
    end

    always_comb begin
        shifted = rspData >> {rspOff, 3'b000};
        case (rspType)
            RW_B:    rspExt = DATA_WIDTH'($signed(shifted[7:0]));
            RW_H:    rspExt = DATA_WIDTH'($signed(shifted[15:0]));
            RW_W:    rspExt = DATA_WIDTH'($signed(shifted[31:0]));
            RW_BU:   rspExt = DATA_WIDTH'(shifted[7:0]);
            RW_HU:   rspExt = DATA_WIDTH'(shifted[15:0]);
            RW_WU:   rspExt = DATA_WIDTH'(shifted[31:0]);
            default: rspExt = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// M-stage load/store unit: validates the core request, runs one bus
// transaction at a time and returns the extended load result.
//
// state | meaning
// IDLE  | accept core request; illegal/misaligned ones fault here
// REQ   | bus_req_valid held with registered fields until accepted
// WAIT  | waiting for bus_rsp_valid; capture data or error
// DONE  | one cycle: stall released, result (or fault) presented
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  R_en,
    input  logic                  W_en,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] Wr_mem_data,
    input  logic [2:0]            RW_type,
    output logic [DATA_WIDTH-1:0] Rd_mem_data,
    output logic                  stall,
    output logic                  fault,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [BE_WIDTH-1:0]   bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rsp_data,
    input  logic                  bus_rsp_err
);

    localparam int OFF_W = $clog2(BE_WIDTH);

    lsuState_t             state, stateNext;
    logic                  reqAny, reqLegal, reqAligned, reqOk, reqBad;
    logic [3:0]            reqSize;
    logic [2:0]            rwTypeQ;
    logic [OFF_W-1:0]      offQ;
    logic                  errQ;
    logic [DATA_WIDTH-1:0] rdataQ;
    logic [BE_WIDTH-1:0]   beNext;
    logic [DATA_WIDTH-1:0] wdataNext;
    logic [DATA_WIDTH-1:0] rspExt;

    riscv_lsu_align #(
        .DATA_WIDTH(DATA_WIDTH),
        .BE_WIDTH  (BE_WIDTH),
        .OFF_W     (OFF_W)
    ) u_align (
        .reqType (RW_type),
        .reqOff  (ram_addr[OFF_W-1:0]),
        .reqData (Wr_mem_data),
        .reqBe   (beNext),
        .reqWdata(wdataNext),
        .rspType (rwTypeQ),
        .rspOff  (offQ),
        .rspData (bus_rsp_data),
        .rspExt  (rspExt)
    );

    // Doubleword and WU only exist on a 64-bit datapath.
    always_comb begin
        reqAny     = R_en | W_en;
        reqSize    = sizeBytes(RW_type);
        reqLegal   = (RW_type != RW_ILL) &&
                     !(DATA_WIDTH == 32 && (RW_type == RW_D || RW_type == RW_WU));
        reqAligned = ((ram_addr[OFF_W-1:0] & OFF_W'(reqSize - 4'd1)) == '0);
        reqOk      = reqAny && reqLegal && reqAligned;
        reqBad     = reqAny && !(reqLegal && reqAligned);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (reqOk)         stateNext = REQ;
            REQ:  if (bus_req_ready) stateNext = WAIT;
            WAIT: if (bus_rsp_valid) stateNext = DONE;
            DONE:                    stateNext = IDLE;
            default:                 stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rwTypeQ   <= RW_B;
            offQ      <= '0;
            errQ      <= 1'b0;
            rdataQ    <= '0;
        end else begin
            if (state == IDLE && reqOk) begin
                bus_we    <= W_en;
                bus_addr  <= {ram_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                bus_be    <= beNext;
                bus_wdata <= wdataNext;
                rwTypeQ   <= RW_type;
                offQ      <= ram_addr[OFF_W-1:0];
            end
            if (state == WAIT && bus_rsp_valid) begin
                errQ   <= bus_rsp_err;
                rdataQ <= (bus_rsp_err || bus_we) ? '0 : rspExt;
            end
        end
    end

    always_comb begin
        bus_req_valid = 1'b0;
        stall         = 1'b0;
        fault         = 1'b0;
        Rd_mem_data   = '0;
        case (state)
            IDLE: begin
                stall = rst_n && reqOk;
                fault = rst_n && reqBad;
            end
            REQ: begin
                bus_req_valid = 1'b1;
                stall         = 1'b1;
            end
            WAIT: stall = 1'b1;
            DONE: begin
                fault       = errQ;
                Rd_mem_data = rdataQ;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu (64-bit datapath): expected bus fields and
// load results are queued at request time and compared when the DUT answers.
module tb_riscv_lsu;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          R_en, W_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] Wr_mem_data;
    logic [2:0]    RW_type;
    logic [DW-1:0] Rd_mem_data;
    logic          stall, fault;
    logic          bus_req_valid, bus_req_ready, bus_we;
    logic [AW-1:0] bus_addr;
    logic [BW-1:0] bus_be;
    logic [DW-1:0] bus_wdata;
    logic          bus_rsp_valid;
    logic [DW-1:0] bus_rsp_data;
    logic          bus_rsp_err;

    riscv_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .R_en(R_en), .W_en(W_en),
        .ram_addr(ram_addr), .Wr_mem_data(Wr_mem_data), .RW_type(RW_type),
        .Rd_mem_data(Rd_mem_data), .stall(stall), .fault(fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [63:0]   addr;
        logic [7:0]    be;
        logic [63:0]   wdata;
        logic [63:0]   rdata;
        logic          flt;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int mdlSize(input logic [2:0] t);
        case (t)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2, 3'd6: return 4;
            3'd3:       return 8;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [7:0] mdlBe(input logic [2:0] t, input int off);
        logic [7:0] r = '0;
        for (int k = 0; k < mdlSize(t); k++) r[off + k] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] mdlWdata(input logic [2:0] t, input int off, input logic [63:0] wd);
        logic [63:0] r = '0;
        for (int k = 0; k < mdlSize(t); k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mdlLoad(input logic [2:0] t, input int off, input logic [63:0] rsp);
        logic [63:0] r = '0;
        int sz = mdlSize(t);
        for (int k = 0; k < sz; k++) r[8*k +: 8] = rsp[8*(off+k) +: 8];
        if (t <= 3'd2 && sz < 8 && r[8*sz-1])
            for (int b = 8*sz; b < 64; b++) r[b] = 1'b1;
        return r;
    endfunction

    // Drive one legal request at a negedge and queue what the DUT must do with it.
    task automatic issueReq(input logic ren, input logic wen, input logic [2:0] t,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] rsp, input logic err);
        exp_t e;
        int off;
        @(negedge clk);
        R_en = ren; W_en = wen; RW_type = t; ram_addr = addr; Wr_mem_data = wd;
        off     = int'(addr[2:0]);
        e.we    = wen;
        e.addr  = {addr[63:3], 3'b000};
        e.be    = mdlBe(t, off);
        e.wdata = mdlWdata(t, off, wd);
        e.rdata = (wen || err) ? 64'd0 : mdlLoad(t, off, rsp);
        e.flt   = err;
        expQ.push_back(e);
        #1;
        total++;
        if (stall !== 1'b1 || fault !== 1'b0) begin
            bad++; $display("FAIL req_cycle stall/fault got=%b%b exp=10", stall, fault);
        end
    endtask

    // Acts as the bus slave for the queued request and checks every cycle of it.
    task automatic serveBus(input int readyDly, input int rspDly,
                            input logic [63:0] rsp, input logic err);
        exp_t e;
        @(negedge clk);
        R_en = 1'b0; W_en = 1'b0; RW_type = 3'b111;
        ram_addr = 64'hDEAD_BEEF_0000_0005; Wr_mem_data = '1;
        #1;
        total++;
        if (expQ.size() == 0) begin
            bad++; $display("FAIL scoreboard_empty got=0 exp=1");
            return;
        end
        e = expQ[0];
        for (int i = 0; i <= readyDly; i++) begin
            total++;
            if (bus_req_valid !== 1'b1 || stall !== 1'b1) begin
                bad++; $display("FAIL req_phase cyc=%0d valid/stall got=%b%b exp=11", i, bus_req_valid, stall);
            end
            total++;
            if ({bus_we, bus_addr, bus_be} !== {e.we, e.addr, e.be}) begin
                bad++; $display("FAIL bus_fields cyc=%0d got=%b/%h/%h exp=%b/%h/%h",
                                i, bus_we, bus_addr, bus_be, e.we, e.addr, e.be);
            end
            if (e.we) begin
                total++;
                if (bus_wdata !== e.wdata) begin
                    bad++; $display("FAIL bus_wdata cyc=%0d got=%h exp=%h", i, bus_wdata, e.wdata);
                end
            end
            bus_req_ready = (i == readyDly);
            bus_rsp_valid = (i != readyDly);
            bus_rsp_data  = 64'h5555_AAAA_5555_AAAA;
            @(negedge clk); #1;
        end
        bus_req_ready = 1'b0;
        for (int j = 0; j <= rspDly; j++) begin
            total++;
            if (bus_req_valid !== 1'b0 || stall !== 1'b1) begin
                bad++; $display("FAIL wait_phase cyc=%0d valid/stall got=%b%b exp=01", j, bus_req_valid, stall);
            end
            bus_rsp_valid = (j == rspDly);
            bus_rsp_data  = (j == rspDly) ? rsp : ~rsp;
            bus_rsp_err   = (j == rspDly) ? err : 1'b0;
            @(negedge clk); #1;
        end
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        e = expQ.pop_front();
        total++;
        if (stall !== 1'b0 || bus_req_valid !== 1'b0) begin
            bad++; $display("FAIL done_stall stall/valid got=%b%b exp=00", stall, bus_req_valid);
        end
        total++;
        if (Rd_mem_data !== e.rdata) begin
            bad++; $display("FAIL done_rdata got=%h exp=%h", Rd_mem_data, e.rdata);
        end
        total++;
        if (fault !== e.flt) begin
            bad++; $display("FAIL done_fault got=%b exp=%b", fault, e.flt);
        end
        @(negedge clk); #1;
        total++;
        if (stall !== 1'b0 || fault !== 1'b0 || Rd_mem_data !== 64'd0 || bus_req_valid !== 1'b0) begin
            bad++; $display("FAIL after_done stall/fault/valid/rdata got=%b%b%b/%h exp=000/0",
                            stall, fault, bus_req_valid, Rd_mem_data);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({bus_req_valid, bus_we, fault, stall} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000", {bus_req_valid, bus_we, fault, stall});
        end
        total++;
        if (bus_addr !== 64'd0 || bus_be !== 8'd0 || bus_wdata !== 64'd0 || Rd_mem_data !== 64'd0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus_addr, bus_be, bus_wdata, Rd_mem_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte();
        issueReq(1'b1, 1'b0, 3'd0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
        serveBus(0, 0, 64'h0000_0000_8000_0000, 1'b0);
    endtask

    task automatic test_store_half();
        issueReq(1'b0, 1'b1, 3'd1, 64'h2006, 64'h1234_5678_9ABC_ABCD, 64'd0, 1'b0);
        serveBus(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    endtask

    task automatic test_misaligned();
        logic [2:0]  types [3] = '{3'd2, 3'd3, 3'd7};
        logic [63:0] addrs [3] = '{64'h1002, 64'h1004, 64'h1000};
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            R_en = (n != 1); W_en = (n == 1); RW_type = types[n]; ram_addr = addrs[n];
            #1;
            total++;
            if (fault !== 1'b1 || stall !== 1'b0 || Rd_mem_data !== 64'd0 || bus_req_valid !== 1'b0) begin
                bad++; $display("FAIL bad_req n=%0d fault/stall/valid got=%b%b%b rdata=%h exp=100 rdata=0",
                                n, fault, stall, bus_req_valid, Rd_mem_data);
            end
            @(negedge clk);
            R_en = 1'b0; W_en = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                total++;
                if (fault !== 1'b0 || bus_req_valid !== 1'b0 || stall !== 1'b0) begin
                    bad++; $display("FAIL bad_req_after n=%0d c=%0d fault/valid/stall got=%b%b%b exp=000",
                                    n, c, fault, bus_req_valid, stall);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_stretch();
        issueReq(1'b1, 1'b0, 3'd3, 64'h3000, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
        serveBus(5, 3, 64'h0123_4567_89AB_CDEF, 1'b0);
    endtask

    task automatic test_bus_error();
        issueReq(1'b1, 1'b0, 3'd6, 64'h4004, 64'd0, 64'hFFFF_FFFF_0000_0000, 1'b1);
        serveBus(0, 1, 64'hFFFF_FFFF_0000_0000, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  types [9] = '{3'd1, 3'd5, 3'd2, 3'd4, 3'd3, 3'd6, 3'd0, 3'd2, 3'd3};
        logic [63:0] addrs [9] = '{64'h6002, 64'h6006, 64'h6004, 64'h6007, 64'h6008,
                                   64'h6000, 64'h7005, 64'h7004, 64'h7000};
        logic [63:0] rsp, wd;
        logic        st;
        for (int n = 0; n < 9; n++) begin
            rsp = {$urandom, $urandom};
            wd  = {$urandom, $urandom};
            st  = (n >= 6);
            issueReq(1'b1, st, types[n], addrs[n], wd, rsp, 1'b0);
            serveBus(n % 2, n % 3, rsp, 1'b0);
        end
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        R_en = 1'b1; RW_type = 3'd3; ram_addr = 64'h5000;
        @(negedge clk);
        R_en = 1'b0;
        #1 bus_req_ready = 1'b1;
        @(negedge clk);
        #1 bus_req_ready = 1'b0;
        total++;
        if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin
            bad++; $display("FAIL rst_wait_pre stall/valid got=%b%b exp=10", stall, bus_req_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_req_valid !== 1'b0 || stall !== 1'b0 || bus_addr !== 64'd0 || bus_be !== 8'd0) begin
            bad++; $display("FAIL rst_wait_now valid/stall got=%b%b addr/be=%h/%h exp=00 0/0",
                            bus_req_valid, stall, bus_addr, bus_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        bus_rsp_valid = 1'b1; bus_rsp_data = 64'h1234_5678_1234_5678;
        @(negedge clk);
        #1 bus_rsp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (stall !== 1'b0 || fault !== 1'b0 || Rd_mem_data !== 64'd0 || bus_req_valid !== 1'b0) begin
                bad++; $display("FAIL late_rsp c=%0d stall/fault/valid got=%b%b%b rdata=%h exp=000 rdata=0",
                                c, stall, fault, bus_req_valid, Rd_mem_data);
            end
            @(negedge clk); #1;
        end
        issueReq(1'b1, 1'b0, 3'd5, 64'h5002, 64'd0, 64'h0000_0000_F00D_0000, 1'b0);
        serveBus(0, 0, 64'h0000_0000_F00D_0000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; R_en = 1'b0; W_en = 1'b0; ram_addr = '0; Wr_mem_data = '0;
        RW_type = 3'd0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        bus_rsp_data = '0; bus_rsp_err = 1'b0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_stretch();
        test_bus_error();
        test_back_to_back();
        test_reset_wait();
        total++;
        if (expQ.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
